div_unit: RTL and testbench

//  Iterative 32-bit signed/unsigned divider for the execute stage, driven by the DIV/DIVU
//  R-type decode (funct path of the main decoder). Produces quotient (to LO) and remainder
//  (to HI), and holds the pipeline via stall while the calculation runs.
//  One radix-2 restoring step per clock.

---
 rtl/div_unit_pkg.sv | 22 ++
 rtl/div_unit_sign_fix.sv | 17 +
 rtl/div_unit.sv | 150 +++++++++++++++
 tb/tb_div_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
//  - DIV/DIVU funct codes (beside MTHI/MTLO) as seen by the main decoder
//  - divider FSM state encoding (2 bits)
//  - number of restoring steps per operation
package div_unit_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = 32;

    localparam logic [5:0] FUNCT_MTHI = 6'h11;
    localparam logic [5:0] FUNCT_MTLO = 6'h13;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_CALC  = 2'd1,
        DIV_DZERO = 2'd2,
        DIV_DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_unit_sign_fix.sv
// Conditional two's-complement negate.
// Used as abs() on the operands at accept (negate = operand is negative)
// and as the sign fix on the quotient/remainder at the end of the divide.
//  value   in   WIDTH  operand
//  negate  in   1      1 = return -value
//  result  out  WIDTH  value or -value (0x8000_0000 maps to itself)
module div_unit_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? ({WIDTH{1'b0}} - value) : value;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Quotient goes to LO, remainder to HI; stall holds IF/ID/EX while busy.
//  clk        in   1      rising-edge clock
//  resetn     in   1      asynchronous active-low reset
//  start      in   1      DIV/DIVU issued in EX (sampled in IDLE only)
//  signed_op  in   1      1 = DIV, 0 = DIVU
//  annul      in   1      EX flush; abandons any operation in flight
//  dividend   in   WIDTH  rs value, latched at accept
//  divisor    in   WIDTH  rt value, latched at accept
//  stall      out  1      pipeline hold
//  done       out  1      one-cycle pulse, lo_out/hi_out valid
//  lo_out     out  WIDTH  quotient
//  hi_out     out  WIDTH  remainder
//
// state     | meaning
// ----------+---------------------------------------------------------
// DIV_IDLE  | waiting for start; operands captured on accept
// DIV_CALC  | one shift/subtract step per cycle, cnt 0..31
// DIV_DZERO | divide by zero; fixed result loaded on exit
// DIV_DONE  | done pulse, results already registered
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_op,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    div_state_t       state;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] quot;     // |dividend| shifting out at the MSB, quotient in at the LSB
    logic [WIDTH-1:0] rem;      // restored remainder; always < divisor so WIDTH bits suffice
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_quot;
    logic [WIDTH-1:0] step_rem;

    // Partial remainder is WIDTH+1 bits; a borrow out of the top bit means restore.
    assign shifted   = {rem, quot[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvsr};
    assign step_quot = {quot[WIDTH-2:0], ~diff[WIDTH]};
    assign step_rem  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

    // The two sign-fix instances are shared: abs() of the operands while
    // idle, sign fix of the final quotient/remainder during the last step.
    logic             is_idle;
    logic [WIDTH-1:0] fix_a_in, fix_b_in, fix_a_out, fix_b_out;
    logic             fix_a_neg, fix_b_neg;

    assign is_idle   = (state == DIV_IDLE);
    assign fix_a_in  = is_idle ? dividend : step_quot;
    assign fix_a_neg = is_idle ? (signed_op & dividend[WIDTH-1]) : neg_q;
    assign fix_b_in  = is_idle ? divisor : step_rem;
    assign fix_b_neg = is_idle ? (signed_op & divisor[WIDTH-1]) : neg_r;

    div_unit_sign_fix #(.WIDTH(WIDTH)) u_fix_a (
        .value  (fix_a_in),
        .negate (fix_a_neg),
        .result (fix_a_out)
    );

    div_unit_sign_fix #(.WIDTH(WIDTH)) u_fix_b (
        .value  (fix_b_in),
        .negate (fix_b_neg),
        .result (fix_b_out)
    );

    assign stall = (is_idle && start && !annul)
                 || (state == DIV_CALC)
                 || (state == DIV_DZERO);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            quot   <= '0;
            rem    <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            lo_out <= '0;
            hi_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= signed_op & dividend[WIDTH-1];
                        cnt   <= '0;
                        rem   <= '0;
                        dvsr  <= fix_b_out;
                        if (divisor == '0) begin
                            // keep the raw dividend: it is the remainder result
                            quot  <= dividend;
                            state <= DIV_DZERO;
                        end else begin
                            quot  <= fix_a_out;
                            state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (annul) begin
                        state <= DIV_IDLE;
                    end else begin
                        quot <= step_quot;
                        rem  <= step_rem;
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'(DIV_CYCLES - 1)) begin
                            lo_out <= fix_a_out;
                            hi_out <= fix_b_out;
                            done   <= 1'b1;
                            state  <= DIV_DONE;
                        end
                    end
                end
                DIV_DZERO: begin
                    if (annul) begin
                        state <= DIV_IDLE;
                    end else begin
                        lo_out <= '1;
                        hi_out <= quot;
                        done   <= 1'b1;
                        state  <= DIV_DONE;
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        stall;
    logic        done;
    logic [31:0] lo_out;
    logic [31:0] hi_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .signed_op (signed_op),
        .annul     (annul),
        .dividend  (dividend),
        .divisor   (divisor),
        .stall     (stall),
        .done      (done),
        .lo_out    (lo_out),
        .hi_out    (hi_out)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: plain integer division with C-style truncation.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle (cycle 0) and follow it to done.
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input int exp_lat);
        int lat;
        int stall_bad;
        lat = -1;
        stall_bad = 0;
        dividend = a;
        divisor = b;
        signed_op = sgn;
        start = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            #1;
            if (stall !== (c < exp_lat)) stall_bad++;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            tick();
            start = 1'b0;
            dividend = $urandom;
            divisor = $urandom;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " stall"}, 32'(stall_bad), 32'd0);
        check({name, " lo"}, lo_out, exp_q);
        check({name, " hi"}, hi_out, exp_r);
        last_q = exp_q;
        last_r = exp_r;
        tick();
        check({name, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        logic [63:0] rr;
        logic [31:0] a, b;
        logic        s;
        int          bad;

        vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33});
        vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          33});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          33});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          33});
        vecs.push_back('{32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          2});
        vecs.push_back('{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  2});
        vecs.push_back('{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          33});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  33});
        vecs.push_back('{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  33});
        vecs.push_back('{32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0,          33});

        // reset state
        #2;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset lo", lo_out, 32'd0);
        check("reset hi", hi_out, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                  vecs[i].q, vecs[i].r, vecs[i].lat);

        // annul and start together in IDLE: annul wins
        start = 1'b1;
        annul = 1'b1;
        dividend = 32'd50;
        divisor = 32'd5;
        #1;
        check("annul_idle stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        annul = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (stall !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        check("annul_idle no_accept", 32'(bad), 32'd0);

        // annul at cycle 10 of a DIVU, restart at cycle 11 -> done at 44
        dividend = 32'd1000;
        divisor = 32'd7;
        signed_op = 1'b0;
        start = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (done !== 1'b0) bad++;
            tick();
            start = 1'b0;
        end
        annul = 1'b1;
        tick();
        annul = 1'b0;
        #1;
        check("annul no_done", 32'(bad), 32'd0);
        check("annul stall", {31'd0, stall}, 32'd0);
        check("annul done", {31'd0, done}, 32'd0);
        check("annul lo_hold", lo_out, last_q);
        check("annul hi_hold", hi_out, last_r);
        do_op("after_annul", 32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 33);

        // asynchronous reset mid-operation
        dividend = 32'd12345;
        divisor = 32'd3;
        signed_op = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            start = 1'b0;
        end
        #2;
        resetn = 1'b0;
        #1;
        check("midreset stall", {31'd0, stall}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset lo", lo_out, 32'd0);
        check("midreset hi", hi_out, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        do_op("after_reset", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

        // randomized operands against the reference model
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = 32'd0 - 32'($urandom_range(1, 15));
                4: a = 32'h8000_0000;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (b == 32'd0 && $urandom_range(0, 3) != 0) b = 32'd1;
            s = 1'($urandom_range(0, 1));
            rr = ref_div(a, b, s);
            do_op($sformatf("rand%0d", i), a, b, s, rr[63:32], rr[31:0], (b == 32'd0) ? 2 : 33);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
